// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM arbiter: port identifiers, byte-to-word
// offset and the misalignment test applied to granted addresses.
package rom_arb_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } rom_port_t;

    localparam int WORD_OFS = 2;

    function automatic logic is_misaligned(input logic [WORD_OFS-1:0] low_bits);
        return low_bits != '0;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Two-way combinational picker: grants a lone requester, and on contention
// grants the port that was not granted last. grant[0] = fetch, grant[1] = load.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  rom_port_t  last,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == PORT_I) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates the single-port synchronous ROM between fetch (i) and load (d).
// Define ROM_ARB_RR_EN for round-robin; otherwise load has fixed priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,

    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    logic [1:0] pick_grant;
    rom_port_t  pick_last;
    logic       gnt_i;
    logic       gnt_d;
    logic       any_gnt;

    logic       resp_valid;
    rom_port_t  resp_port;
    logic       resp_err;

`ifdef ROM_ARB_RR_EN
    rom_port_t  rr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= PORT_I;
        end else if (any_gnt) begin
            rr_last <= gnt_d ? PORT_D : PORT_I;
        end
    end

    assign pick_last = rr_last;
`else
    // Tying last to fetch makes every contention resolve in favour of load.
    assign pick_last = PORT_I;
`endif

    rom_arb_pick u_pick (
        .req   ({d_req, i_req}),
        .last  (pick_last),
        .grant (pick_grant)
    );

    assign gnt_i   = pick_grant[0] & ~rst;
    assign gnt_d   = pick_grant[1] & ~rst;
    assign any_gnt = gnt_i | gnt_d;

    assign i_gnt = gnt_i;
    assign d_gnt = gnt_d;

    always_comb begin
        rom_addr = '0;
        if (gnt_d) begin
            rom_addr = d_addr;
        end else if (gnt_i) begin
            rom_addr = i_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_port  <= PORT_I;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= any_gnt;
            resp_port  <= gnt_d ? PORT_D : PORT_I;
            resp_err   <= any_gnt & is_misaligned(rom_addr[WORD_OFS-1:0]);
        end
    end

    // Responses are gated by the registered valid, so reset clears them at once.
    assign i_rvalid = resp_valid & (resp_port == PORT_I);
    assign d_rvalid = resp_valid & (resp_port == PORT_D);
    assign i_rdata  = i_rvalid ? rom_data : '0;
    assign d_rdata  = d_rvalid ? rom_data : '0;
    assign i_err    = i_rvalid & resp_err;
    assign d_err    = d_rvalid & resp_err;

endmodule
